// File: rtl/xcvr_port_pkg.sv
// Shared types and constants for the 74245 transceiver port controller.
// Direction encodings follow the 74245 DIR pin: high moves A (CPU) to B (peripheral).
package xcvr_port_pkg;

    localparam int   BYTE_W  = 8;
    localparam logic DIR_A2B = 1'b1;
    localparam logic DIR_B2A = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TURN   = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    // A turnaround gap is needed whenever the transceiver must reverse direction.
    function automatic logic needs_turn(input logic cur_dir, input logic new_dir);
        return (cur_dir != new_dir);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered occupancy; pushes are dropped when full
// and pops are ignored when empty, so callers may present requests unconditionally.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == AW'(0) + (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/xcvr_port_ctrl.sv
// Sequences direction and output enable of a 74245 between CPU bus (A) and peripheral (B),
// buffering inbound bytes in a FIFO and holding the last outbound byte for the peripheral.
module xcvr_port_ctrl
    import xcvr_port_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        nMR,
    input  logic                        rd_req,
    input  logic                        wr_req,
    output logic                        rd_done,
    output logic                        wr_done,
    output logic                        xcvr_dir,
    output logic                        xcvr_nOE,
    output logic [BYTE_W-1:0]           b_out,
    output logic                        b_oe,
    input  logic [BYTE_W-1:0]           b_in,
    input  logic [BYTE_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [BYTE_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        underflow,
    output logic                        busy
);

    localparam int CNT_MAX = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t                     state_r;
    logic [CNT_W-1:0]           cnt_r;
    logic                       dir_r;
    logic                       noe_r;
    logic                       boe_r;
    logic [BYTE_W-1:0]          bout_r;
    logic                       rd_done_r;
    logic                       wr_done_r;
    logic                       busy_r;
    logic                       underflow_r;
    logic                       rd_empty_r;
    logic [BYTE_W-1:0]          out_data_r;
    logic                       out_valid_r;

    logic                       last_s;
    logic                       go_turn_s;
    logic                       go_drive_s;
    logic                       go_sample_s;
    logic                       new_dir_s;
    logic                       drive_done_s;
    logic                       sample_done_s;
    logic                       push_s;
    logic                       pop_s;
    logic [BYTE_W-1:0]          fifo_head_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_in_fifo (
        .clk   (clk),
        .rst_n (nMR),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_data),
        .head  (fifo_head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Request arbitration and phase advance; reads win over a simultaneous write.
    always_comb begin
        go_turn_s   = 1'b0;
        go_drive_s  = 1'b0;
        go_sample_s = 1'b0;
        new_dir_s   = dir_r;
        last_s      = (cnt_r == {CNT_W{1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (rd_req) begin
                    new_dir_s = DIR_B2A;
                    if (needs_turn(dir_r, DIR_B2A) && (TURN_CYCLES > 32'sd0)) begin
                        go_turn_s = 1'b1;
                    end else begin
                        go_drive_s = 1'b1;
                    end
                end else if (wr_req && !out_valid_r) begin
                    new_dir_s = DIR_A2B;
                    if (needs_turn(dir_r, DIR_A2B) && (TURN_CYCLES > 32'sd0)) begin
                        go_turn_s = 1'b1;
                    end else begin
                        go_sample_s = 1'b1;
                    end
                end else begin
                    new_dir_s = dir_r;
                end
            end
            ST_TURN: begin
                if (last_s) begin
                    if (dir_r == DIR_B2A) begin
                        go_drive_s = 1'b1;
                    end else begin
                        go_sample_s = 1'b1;
                    end
                end else begin
                    go_drive_s = 1'b0;
                end
            end
            default: begin
                new_dir_s = dir_r;
            end
        endcase
    end

    assign drive_done_s  = (state_r == ST_DRIVE) && last_s;
    assign sample_done_s = (state_r == ST_SAMPLE) && last_s;
    assign push_s        = in_valid && !fifo_full_s;
    // Pop only the byte that was actually presented; a byte pushed mid-read is kept.
    assign pop_s         = drive_done_s && !rd_empty_r;

    // Transfer sequencer: state, turn/hold counter and transceiver-facing outputs.
    always_ff @(posedge clk or negedge nMR) begin
        if (!nMR) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            dir_r       <= DIR_A2B;
            noe_r       <= 1'b1;
            boe_r       <= 1'b0;
            bout_r      <= {BYTE_W{1'b0}};
            rd_done_r   <= 1'b0;
            wr_done_r   <= 1'b0;
            busy_r      <= 1'b0;
            underflow_r <= 1'b0;
            rd_empty_r  <= 1'b0;
        end else begin
            rd_done_r <= 1'b0;
            wr_done_r <= 1'b0;
            dir_r     <= new_dir_s;
            if (go_turn_s) begin
                state_r <= ST_TURN;
                cnt_r   <= TURN_LOAD;
                busy_r  <= 1'b1;
            end else if (go_drive_s) begin
                state_r    <= ST_DRIVE;
                cnt_r      <= HOLD_LOAD;
                noe_r      <= 1'b0;
                boe_r      <= 1'b1;
                bout_r     <= fifo_empty_s ? {BYTE_W{1'b0}} : fifo_head_s;
                rd_empty_r <= fifo_empty_s;
                busy_r     <= 1'b1;
                if (fifo_empty_s) begin
                    underflow_r <= 1'b1;
                end
            end else if (go_sample_s) begin
                state_r <= ST_SAMPLE;
                cnt_r   <= HOLD_LOAD;
                noe_r   <= 1'b0;
                busy_r  <= 1'b1;
            end else if (drive_done_s) begin
                state_r   <= ST_IDLE;
                boe_r     <= 1'b0;
                noe_r     <= 1'b1;
                rd_done_r <= 1'b1;
                busy_r    <= 1'b0;
            end else if (sample_done_s) begin
                state_r   <= ST_IDLE;
                noe_r     <= 1'b1;
                wr_done_r <= 1'b1;
                busy_r    <= 1'b0;
            end else if (state_r != ST_IDLE) begin
                cnt_r <= cnt_r - CNT_W'(1'b1);
            end
        end
    end

    // Outbound holding register; a capture on the same edge as out_ready keeps it full.
    always_ff @(posedge clk or negedge nMR) begin
        if (!nMR) begin
            out_data_r  <= {BYTE_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (sample_done_s) begin
            out_data_r  <= b_in;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign rd_done    = rd_done_r;
    assign wr_done    = wr_done_r;
    assign xcvr_dir   = dir_r;
    assign xcvr_nOE   = noe_r;
    assign b_out      = bout_r;
    assign b_oe       = boe_r;
    assign in_ready   = !fifo_full_s;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign fifo_count = fifo_count_s;
    assign underflow  = underflow_r;
    assign busy       = busy_r;

endmodule
